mmio_uart: RTL and testbench

- Memory-mapped UART peripheral on the single-cycle core's data bus; sits beside data memory and the IO memory behind the address decoder and read-data mux.
- Next generation of the loopback UART: parametrised TX/RX FIFOs, a programmable baud divisor, status/control registers, a selectable internal loopback and an interrupt output.
- Reads are combinational, so the core gets data in the same cycle. Writes and RX pops take effect on the clock edge.

---
 rtl/mmio_uart.sv | 250 +++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, sticky status flags,
// internal loopback and a level interrupt. Reads are combinational; writes and RX pops act on the edge.

module mmio_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr, wptr_n, rptr_n;

    assign wptr_n = push ? wptr + (AW+1)'(1) : wptr;
    assign rptr_n = pop  ? rptr + (AW+1)'(1) : rptr;
    assign dout   = mem[rptr[AW-1:0]];

    // Flags are registered so irq is a function of flops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            empty <= (wptr_n == rptr_n);
            full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// state | meaning
// IDLE  | line idle; TX waits for FIFO data, RX waits for a synchronised 0
// START | start bit (TX drives 0 for divisor clocks, RX waits divisor/2 and re-checks)
// DATA  | 8 data bits, LSB first, one per divisor clocks
// STOP  | stop bit (TX drives 1, RX samples and pushes the byte)
module mmio_uart #(
    parameter int               Width     = 32,
    parameter logic [Width-1:0] BASE_ADDR = 'h0000_1000,
    parameter int               TX_DEPTH  = 8,
    parameter int               RX_DEPTH  = 8,
    parameter int               DIV_RESET = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memWrite,
    input  logic             memRead,
    input  logic [Width-1:0] address,
    input  logic [Width-1:0] WriteData,
    output logic [Width-1:0] ReadData,
    output logic             Tx,
    input  logic             Rx,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic       sel;
    logic [1:0] idx;
    logic       wr_data, wr_status, wr_ctrl, rd_data;
    assign sel       = (address[Width-1:4] == BASE_ADDR[Width-1:4]);
    assign idx       = address[3:2];
    assign wr_data   = memWrite && sel && (idx == 2'd0);
    assign wr_status = memWrite && sel && (idx == 2'd1);
    assign wr_ctrl   = memWrite && sel && (idx == 2'd2);
    assign rd_data   = memRead  && sel && (idx == 2'd0);

    logic unused_bits;
    assign unused_bits = ^{address[1:0], WriteData[Width-1:19]};

    logic [15:0] divisor;
    logic        loopback, rx_irq_en, tx_irq_en;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor   <= 16'(DIV_RESET);
            loopback  <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            divisor   <= (WriteData[15:0] < 16'd2) ? 16'd2 : WriteData[15:0];
            loopback  <= WriteData[16];
            rx_irq_en <= WriteData[17];
            tx_irq_en <= WriteData[18];
        end
    end

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_done;
    logic [7:0] tx_head, rx_head, rx_shift;

    // A full FIFO still accepts a write when the same edge frees a slot.
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign rx_pop  = rd_data && !rx_empty;
    assign rx_push = rx_done && (!rx_full || rx_pop);

    mmio_uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(WriteData[7:0]),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );
    mmio_uart_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tc;
    assign tx_tc = (tx_cnt == 16'd0);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        Tx      = 1'b1;
        case (tx_state)
            IDLE:    if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
            START:   begin Tx = 1'b0; if (tx_tc) tx_next = DATA; end
            DATA:    begin Tx = tx_shift[0]; if (tx_tc && tx_bit == 3'd7) tx_next = STOP; end
            STOP:    if (tx_tc) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= divisor;
                tx_cnt   <= divisor - 16'd1;
                tx_bit   <= '0;
            end else if (tx_state != IDLE) begin
                if (tx_tc) begin
                    tx_cnt <= tx_div - 16'd1;
                    if (tx_state == DATA) begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    logic [1:0] rx_sync;
    logic       rx_s;
    assign rx_s = rx_sync[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], loopback ? Tx : Rx};
    end

    uart_state_t rx_state, rx_next;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic        rx_start, rx_tc;
    assign rx_tc = (rx_cnt == 16'd0);

    always_comb begin
        rx_next  = rx_state;
        rx_start = 1'b0;
        rx_done  = 1'b0;
        case (rx_state)
            IDLE:    if (!rx_s) begin rx_start = 1'b1; rx_next = START; end
            START:   if (rx_tc) rx_next = rx_s ? IDLE : DATA;
            DATA:    if (rx_tc && rx_bit == 3'd7) rx_next = STOP;
            STOP:    if (rx_tc) begin rx_done = 1'b1; rx_next = IDLE; end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_start) begin
                rx_div <= divisor;
                rx_cnt <= (divisor >> 1) - 16'd1;
                rx_bit <= '0;
            end else if (rx_state != IDLE) begin
                if (rx_tc) begin
                    rx_cnt <= rx_div - 16'd1;
                    if (rx_state == DATA) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 16'd1;
                end
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a W1C wins.
    logic rx_ovr, tx_ovf, frame_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovr    <= 1'b0;
            tx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_ovr    <= (rx_ovr && !(wr_status && WriteData[5])) || (rx_done && rx_full && !rx_pop);
            tx_ovf    <= (tx_ovf && !(wr_status && WriteData[6])) || (wr_data && tx_full && !tx_pop);
            frame_err <= (frame_err && !(wr_status && WriteData[7])) || (rx_done && !rx_s);
        end
    end

    logic [7:0] status;
    assign status = {frame_err, tx_ovf, rx_ovr, (tx_state != IDLE), rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (idx)
                2'd0:    ReadData = rx_empty ? '0 : Width'(rx_head);
                2'd1:    ReadData = Width'(status);
                2'd2:    ReadData = Width'({tx_irq_en, rx_irq_en, loopback, divisor});
                default: ReadData = '0;
            endcase
        end
    end

    assign irq = (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty);
endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register table plus serial, FIFO, flag, irq and reset sequences.

module tb_mmio_uart;
    localparam logic [31:0] A_DATA = 32'h0000_1000;
    localparam logic [31:0] A_STAT = 32'h0000_1004;
    localparam logic [31:0] A_CTRL = 32'h0000_1008;
    localparam logic [31:0] A_RSVD = 32'h0000_100C;

    logic        clk = 1'b0;
    logic        rst_n, memWrite, memRead, Rx, Tx, irq;
    logic [31:0] address, WriteData, ReadData, d;
    int          checks = 0;
    int          failures = 0;

    mmio_uart dut (
        .clk(clk), .rst_n(rst_n), .memWrite(memWrite), .memRead(memRead),
        .address(address), .WriteData(WriteData), .ReadData(ReadData),
        .Tx(Tx), .Rx(Rx), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        address = a; WriteData = v; memWrite = 1'b1;
        @(negedge clk);
        memWrite = 1'b0;
    endtask

    task automatic burst(input logic [7:0] first, input int n);
        @(negedge clk);
        address = A_DATA; memWrite = 1'b1;
        for (int i = 0; i < n; i++) begin
            WriteData = 32'(first) + 32'(i);
            @(negedge clk);
        end
        memWrite = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        address = a;
        #1 v = ReadData;
    endtask

    // Call at a falling edge: pops on the following rising edge.
    task automatic pop(output logic [31:0] v);
        address = A_DATA; memRead = 1'b1;
        #1 v = ReadData;
        @(negedge clk);
        memRead = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; memWrite = 1'b0; memRead = 1'b0;
        address = '0; WriteData = '0; Rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        Rx = b;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame_a5;
        logic [9:0] frame_3c;
        frame_a5 = 10'b11_0100_1010;  // stop,stop? no: {stop, data[7:0], start} reversed below
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        frame_3c = {1'b0, 8'h3C, 1'b0};

        vecs[0]  = '{"rst_status",  1'b0, 32'h0,        32'h0,        A_STAT,       32'h0000_0006};
        vecs[1]  = '{"rst_ctrl",    1'b0, 32'h0,        32'h0,        A_CTRL,       32'h0000_01B2};
        vecs[2]  = '{"rst_data",    1'b0, 32'h0,        32'h0,        A_DATA,       32'h0};
        vecs[3]  = '{"rsvd_rd",     1'b0, 32'h0,        32'h0,        A_RSVD,       32'h0};
        vecs[4]  = '{"div1_clamp",  1'b1, A_CTRL,       32'h0000_0001, A_CTRL,      32'h0000_0002};
        vecs[5]  = '{"div0_clamp",  1'b1, A_CTRL,       32'h0000_0000, A_CTRL,      32'h0000_0002};
        vecs[6]  = '{"ctrl_en",     1'b1, A_CTRL,       32'h0006_0010, A_CTRL,      32'h0006_0010};
        vecs[7]  = '{"ctrl_all",    1'b1, A_CTRL,       32'hFFFF_FFFF, A_CTRL,      32'h0007_FFFF};
        vecs[8]  = '{"rsvd_wr",     1'b1, A_RSVD,       32'hFFFF_FFFF, A_RSVD,      32'h0};
        vecs[9]  = '{"unsel_wr",    1'b1, 32'h0000_2008, 32'h0000_0005, A_CTRL,     32'h0007_FFFF};
        vecs[10] = '{"unsel_rd",    1'b0, 32'h0,        32'h0,        32'h0000_2008, 32'h0};
        vecs[11] = '{"below_base",  1'b0, 32'h0,        32'h0,        32'h0000_0FF8, 32'h0};
        vecs[12] = '{"w1c_noflag",  1'b1, A_STAT,       32'h0000_00FF, A_STAT,      32'h0000_0006};
        vecs[13] = '{"ctrl_div4",   1'b1, A_CTRL,       32'h0000_0004, A_CTRL,      32'h0000_0004};

        do_reset();
        #1;
        check("rst_tx", 32'(Tx), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_wr) bus_wr(vecs[i].waddr, vecs[i].wdata);
            else @(negedge clk);
            peek(vecs[i].raddr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // Loopback frame 0xA5 at 4 clocks per bit, sampled mid-bit.
        bus_wr(A_CTRL, 32'h0001_0004);
        bus_wr(A_DATA, 32'h0000_00A5);
        @(posedge clk);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 check($sformatf("tx_bit%0d", k), 32'(Tx), 32'(frame_a5[k]));
            if (k == 9) begin
                peek(A_STAT, d);
                check("rx_empty_before_stop", 32'(d[2]), 32'h1);
            end
            repeat (4) @(posedge clk);
        end
        #1 peek(A_STAT, d);
        check("rx_latency", 32'(d[2]), 32'h0);
        @(negedge clk);
        pop(d);
        check("rx_a5", d, 32'h0000_00A5);
        peek(A_STAT, d);
        check("after_pop_status", d, 32'h0000_0006);

        // TX FIFO: 9 accepted back-to-back, 10th overflows, W1C clears.
        do_reset();
        bus_wr(A_CTRL, 32'h0000_0004);
        burst(8'h30, 9);
        peek(A_STAT, d);
        check("tx_9_accepted", d, 32'h0000_0015);
        burst(8'h39, 1);
        peek(A_STAT, d);
        check("tx_ovf_set", d, 32'h0000_0055);
        bus_wr(A_STAT, 32'h0000_0040);
        peek(A_STAT, d);
        check("tx_ovf_clear", d, 32'h0000_0015);

        // RX overflow via loopback: 9 bytes, keep first 8.
        do_reset();
        bus_wr(A_CTRL, 32'h0001_0004);
        burst(8'h10, 9);
        repeat (450) @(negedge clk);
        peek(A_STAT, d);
        check("rx_ovr_status", d, 32'h0000_002A);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pop(d);
            check($sformatf("rx_ovr_byte%0d", i), d, 32'h10 + 32'(i));
        end
        peek(A_STAT, d);
        check("rx_drained", d, 32'h0000_0026);

        // Full RX with a pop on the push edge: byte accepted, no flag.
        bus_wr(A_STAT, 32'h0000_0020);
        burst(8'h20, 8);
        repeat (400) @(negedge clk);
        peek(A_STAT, d);
        check("rx_full_again", d, 32'h0000_000A);
        bus_wr(A_DATA, 32'h0000_0028);
        repeat (41) @(negedge clk);
        pop(d);
        check("simul_pop_byte", d, 32'h0000_0020);
        peek(A_STAT, d);
        check("simul_no_ovr", d, 32'h0000_000A);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pop(d);
            check($sformatf("simul_byte%0d", i), d, 32'h21 + 32'(i));
        end

        // External Rx, div 8: bad stop bit, then a short glitch.
        do_reset();
        bus_wr(A_CTRL, 32'h0000_0008);
        for (int k = 0; k < 10; k++) send_bit(frame_3c[k]);
        @(negedge clk);
        Rx = 1'b1;
        repeat (30) @(negedge clk);
        peek(A_STAT, d);
        check("frame_err_status", d, 32'h0000_0082);
        @(negedge clk);
        pop(d);
        check("rx_3c", d, 32'h0000_003C);
        bus_wr(A_STAT, 32'h0000_0080);
        peek(A_STAT, d);
        check("frame_err_clear", d, 32'h0000_0006);
        @(negedge clk);
        Rx = 1'b0;
        repeat (3) @(negedge clk);
        Rx = 1'b1;
        repeat (30) @(negedge clk);
        peek(A_STAT, d);
        check("glitch_status", d, 32'h0000_0006);
        peek(A_DATA, d);
        check("glitch_data", d, 32'h0);

        // irq from RX data, drops after the pop; tx_irq_en with empty TX.
        do_reset();
        bus_wr(A_CTRL, 32'h0003_0004);
        check("irq_idle", 32'(irq), 32'h0);
        bus_wr(A_DATA, 32'h0000_005A);
        repeat (50) @(negedge clk);
        check("irq_rx", 32'(irq), 32'h1);
        pop(d);
        check("irq_byte", d, 32'h0000_005A);
        check("irq_drop", 32'(irq), 32'h0);
        bus_wr(A_CTRL, 32'h0004_0004);
        check("irq_tx_empty", 32'(irq), 32'h1);

        // Reset mid-frame.
        bus_wr(A_CTRL, 32'h0001_0004);
        burst(8'h61, 3);
        repeat (2) @(negedge clk);
        check("tx_start_low", 32'(Tx), 32'h0);
        rst_n = 1'b0;
        #1 check("rst_tx_immediate", 32'(Tx), 32'h1);
        peek(A_STAT, d);
        check("rst_fifos_empty", d, 32'h0000_0006);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        peek(A_STAT, d);
        check("post_rst_status", d, 32'h0000_0006);
        peek(A_DATA, d);
        check("post_rst_data", d, 32'h0);
        check("post_rst_tx", 32'(Tx), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
